mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Consumer side of the Execute->Memory pipeline register in the pipelined RV32I core.
- Takes the M-stage control and data signals and performs loads and stores over a req/ready/rvalid data-memory handshake.
- Applies byte/half/word lane steering and load sign/zero extension.
- Stalls upstream stages while an access is outstanding, and registers results into the Memory->Writeback boundary.

Parameters:
- DATA_WIDTH, 32, datapath and memory data width (only 32 supported).
- ADDRESS_WIDTH, 32, memory address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- RegWriteM  in  1  M-stage register-write enable.
- ResultSrcM  in  1  1 = load (result from memory), 0 = ALU result.
- MemWriteM  in  1  M-stage store enable.
- Funct3M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- ALUResultM  in  DATA_WIDTH  effective address or ALU result.
- WriteDataM  in  DATA_WIDTH  store data (rs2).
- RdM  in  5  destination register.
- PCPlus4M  in  DATA_WIDTH  PC+4 for jump writeback.
- mem_req  out  1  access request.
- mem_we  out  1  1 = store.
- mem_addr  out  ADDRESS_WIDTH  word-aligned address ({ALUResultM[31:2],2'b00}).
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  DATA_WIDTH  load data word.
- StallM  out  1  hold F/D/E/M pipeline registers.
- RegWriteW  out  1  registered writeback enable.
- ResultSrcW  out  1  registered result select.
- ReadDataW  out  DATA_WIDTH  extended load data.
- ALUResultW  out  DATA_WIDTH  registered ALU result.
- RdW  out  5  registered destination.
- PCPlus4W  out  DATA_WIDTH  registered PC+4.
- MisalignW  out  1  one-cycle fault pulse for a misaligned or illegal access.

Behaviour:
- Reset: state IDLE; every W output is 0; mem_req, mem_we, mem_be and StallM are 0 while rst=1.
- Reset during WAIT_RSP abandons the access. An mem_rvalid arriving later is ignored.
- Access definitions: store = MemWriteM. load = ResultSrcM && !MemWriteM; a store takes priority if both are set.
- Legal access: Funct3M is in the list above (stores use 000/001/010 only) and the address is aligned. Alignment: half needs addr[0]=0; word needs addr[1:0]=00.
- FSM states are IDLE and WAIT_RSP.
- IDLE, no access: W registers load from the M inputs every cycle; StallM=0; latency 1 cycle.
- IDLE, illegal or misaligned access: no mem_req; W captures a bubble (RegWriteW=0); MisalignW=1 for 1 cycle; StallM=0.
- IDLE, legal store: mem_req=mem_we=1 combinationally.
  - If mem_ready: complete; W loads from M with RegWriteW as given; StallM=0.
  - Else: StallM=1, W bubble, request held stable.
- IDLE, legal load: mem_req=1, mem_we=0, mem_be=0.
  - If mem_ready: go to WAIT_RSP.
  - StallM=1 and W bubble in both cases.
- WAIT_RSP: mem_req=0; StallM=1; W bubble each cycle.
  - On mem_rvalid: ReadDataW = extended lane; other W outputs load from the held M inputs; StallM=0; go to IDLE.
- Minimum latencies: store 1 cycle; load 2 cycles (ready in cycle 0, rvalid in cycle 1).
- mem_rvalid in IDLE is ignored.
- Store lanes:
  - SB: wdata = {4{rs2[7:0]}}, be = 0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, be = 0011 << addr[1:0].
  - SW: be = 1111.
- Load extension: select the byte at addr[1:0] or the half at addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- M inputs are held stable by upstream while StallM=1. The block does not re-latch them.

Test Plan:
- Two ALU ops back-to-back (RdM=5 then 6, mem idle) -> RdW=5 then 6 on consecutive cycles; StallM=0; mem_req=0.
- SB addr 0x103, rs2=0x000000AB, mem_ready=1 -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x100; StallM=0; single-cycle completion.
- LB addr 0x102, ready in cycle 0, rvalid in cycle 2, rdata=0x12804567 -> StallM=1 for cycles 0-1; ReadDataW=0xFFFFFF80 after cycle 2; exactly one RegWriteW=1 pulse.
- LHU addr 0x102 with same rdata -> ReadDataW=0x00001280. SW with mem_ready low for 3 cycles -> mem_req/addr/data held stable; StallM=1 for 3 cycles.
- LW addr 0x101 -> no mem_req; MisalignW=1 for 1 cycle; RegWriteW=0; StallM=0.
- rst asserted in WAIT_RSP, rvalid on the next cycle -> state IDLE, all W outputs 0, rvalid ignored; the next ALU op flows normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory stage of the pipelined RV32I core: drives the data-memory req/ready/rvalid handshake,
// steers store lanes, extends load data and registers results into the M->W boundary.
module mem_access_stage #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     RegWriteM,
    input  logic                     ResultSrcM,
    input  logic                     MemWriteM,
    input  logic [2:0]               Funct3M,
    input  logic [DATA_WIDTH-1:0]    ALUResultM,
    input  logic [DATA_WIDTH-1:0]    WriteDataM,
    input  logic [4:0]               RdM,
    input  logic [DATA_WIDTH-1:0]    PCPlus4M,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     mem_ready,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     StallM,
    output logic                     RegWriteW,
    output logic                     ResultSrcW,
    output logic [DATA_WIDTH-1:0]    ReadDataW,
    output logic [DATA_WIDTH-1:0]    ALUResultW,
    output logic [4:0]               RdW,
    output logic [DATA_WIDTH-1:0]    PCPlus4W,
    output logic                     MisalignW
);

    typedef enum logic [0:0] {
        IDLE,
        WAIT_RSP
    } state_t;

    state_t state_q, state_d;

    logic                  is_store;
    logic                  is_load;
    logic                  funct3_ok;
    logic                  aligned;
    logic                  legal;
    logic [1:0]            addr_lo;
    logic [3:0]            store_be;
    logic [DATA_WIDTH-1:0] store_data;
    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  capture;
    logic                  misalign_d;
    logic [DATA_WIDTH-1:0] rdata_d;

    // A store wins when both store and load controls are set.
    assign is_store = MemWriteM;
    assign is_load  = ResultSrcM && !MemWriteM;
    assign addr_lo  = ALUResultM[1:0];

    always_comb begin
        funct3_ok = 1'b0;
        case (Funct3M)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = !is_store;
            default:                funct3_ok = 1'b0;
        endcase
    end

    always_comb begin
        aligned = 1'b1;
        case (Funct3M[1:0])
            2'b01:   aligned = (addr_lo[0] == 1'b0);
            2'b10:   aligned = (addr_lo == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign legal = funct3_ok && aligned;

    assign mem_addr = {ALUResultM[ADDRESS_WIDTH-1:2], 2'b00};

    always_comb begin
        store_be   = 4'b1111;
        store_data = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                store_be   = 4'b0001 << addr_lo;
                store_data = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                store_be   = 4'b0011 << addr_lo;
                store_data = {2{WriteDataM[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = WriteDataM;
            end
        endcase
    end

    assign mem_wdata = store_data;

    always_comb begin
        load_byte = mem_rdata[7:0];
        case (addr_lo)
            2'b00:   load_byte = mem_rdata[7:0];
            2'b01:   load_byte = mem_rdata[15:8];
            2'b10:   load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
    end

    assign load_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = '0;
        case (Funct3M)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b010:  load_ext = mem_rdata;
            3'b100:  load_ext = {24'h0, load_byte};
            3'b101:  load_ext = {16'h0, load_half};
            default: load_ext = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        StallM     = 1'b0;
        capture    = 1'b0;
        misalign_d = 1'b0;
        rdata_d    = '0;
        case (state_q)
            IDLE: begin
                if (is_store || is_load) begin
                    if (!legal) begin
                        misalign_d = 1'b1;
                    end else if (is_store) begin
                        mem_req = 1'b1;
                        mem_we  = 1'b1;
                        mem_be  = store_be;
                        if (mem_ready) begin
                            capture = 1'b1;
                        end else begin
                            StallM = 1'b1;
                        end
                    end else begin
                        mem_req = 1'b1;
                        StallM  = 1'b1;
                        if (mem_ready) begin
                            state_d = WAIT_RSP;
                        end
                    end
                end else begin
                    capture = 1'b1;
                end
            end
            WAIT_RSP: begin
                StallM = 1'b1;
                if (mem_rvalid) begin
                    StallM  = 1'b0;
                    capture = 1'b1;
                    rdata_d = load_ext;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Keep the memory port and the stall quiet while reset is held.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            mem_be  = 4'b0000;
            StallM  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            ReadDataW  <= '0;
            ALUResultW <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            MisalignW  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ReadDataW <= rdata_d;
            MisalignW <= misalign_d;
            if (capture) begin
                RegWriteW  <= RegWriteM;
                ResultSrcW <= ResultSrcM;
                ALUResultW <= ALUResultM;
                RdW        <= RdM;
                PCPlus4W   <= PCPlus4M;
            end else begin
                RegWriteW  <= 1'b0;
                ResultSrcW <= 1'b0;
                ALUResultW <= '0;
                RdW        <= '0;
                PCPlus4W   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected writeback results are queued when an op is
// driven and compared when the stage retires it.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, ResultSrcM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        StallM, RegWriteW, ResultSrcW, MisalignW;
    logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
    logic [4:0]  RdW;

    typedef struct {
        logic        regw;
        logic        rsrc;
        logic        chk_rdata;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] pc4;
    } wb_t;

    wb_t wb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    mem_access_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW),
        .ALUResultW(ALUResultW), .RdW(RdW), .PCPlus4W(PCPlus4W), .MisalignW(MisalignW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic rs, input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc4);
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemWriteM  = mw;
        Funct3M    = f3;
        ALUResultM = alu;
        WriteDataM = wd;
        RdM        = rd;
        PCPlus4M   = pc4;
    endtask

    task automatic push(input logic chk_rdata, input logic [31:0] rdata);
        wb_t e;
        e.regw      = RegWriteM;
        e.rsrc      = ResultSrcM;
        e.chk_rdata = chk_rdata;
        e.rdata     = rdata;
        e.alu       = ALUResultM;
        e.rd        = RdM;
        e.pc4       = PCPlus4M;
        wb_q.push_back(e);
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        if (wb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = wb_q.pop_front();
            chk({tag, "_RegWriteW"}, {31'd0, RegWriteW}, {31'd0, e.regw});
            chk({tag, "_ResultSrcW"}, {31'd0, ResultSrcW}, {31'd0, e.rsrc});
            chk({tag, "_ALUResultW"}, ALUResultW, e.alu);
            chk({tag, "_RdW"}, {27'd0, RdW}, {27'd0, e.rd});
            chk({tag, "_PCPlus4W"}, PCPlus4W, e.pc4);
            chk({tag, "_MisalignW"}, {31'd0, MisalignW}, 32'd0);
            if (e.chk_rdata) chk({tag, "_ReadDataW"}, ReadDataW, e.rdata);
        end
    endtask

    task automatic check_bubble(input string tag);
        chk({tag, "_bubble_RegWriteW"}, {31'd0, RegWriteW}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
        tick();
        tick();
        // A load presented during reset must not request.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd3, 32'h4);
        mem_ready = 1'b1;
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_StallM", {31'd0, StallM}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        chk("rst_RdW", {27'd0, RdW}, 32'd0);
        chk("rst_ALUResultW", ALUResultW, 32'd0);
        chk("rst_PCPlus4W", PCPlus4W, 32'd0);
        chk("rst_MisalignW", {31'd0, MisalignW}, 32'd0);
        tick();
        rst       = 1'b0;
        mem_ready = 1'b0;

        // Back-to-back ALU ops.
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h11, 32'h0, 5'd5, 32'h1004);
        #1;
        chk("alu0_mem_req", {31'd0, mem_req}, 32'd0);
        chk("alu0_StallM", {31'd0, StallM}, 32'd0);
        push(1'b0, 32'h0);
        tick();
        check_wb("alu0");
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h22, 32'h0, 5'd6, 32'h1008);
        #1;
        chk("alu1_StallM", {31'd0, StallM}, 32'd0);
        push(1'b0, 32'h0);
        tick();
        check_wb("alu1");

        // SB at 0x103 with ready.
        drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h103, 32'h000000AB, 5'd0, 32'h100C);
        mem_ready = 1'b1;
        #1;
        chk("sb_mem_req", {31'd0, mem_req}, 32'd1);
        chk("sb_mem_we", {31'd0, mem_we}, 32'd1);
        chk("sb_mem_be", {28'd0, mem_be}, 32'h8);
        chk("sb_mem_wdata", mem_wdata, 32'hABABABAB);
        chk("sb_mem_addr", mem_addr, 32'h100);
        chk("sb_StallM", {31'd0, StallM}, 32'd0);
        push(1'b0, 32'h0);
        tick();
        check_wb("sb");

        // SH at 0x102: upper half lanes.
        drive(1'b0, 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 5'd0, 32'h1010);
        #1;
        chk("sh_mem_be", {28'd0, mem_be}, 32'hC);
        chk("sh_mem_wdata", mem_wdata, 32'hBEEFBEEF);
        push(1'b0, 32'h0);
        tick();
        check_wb("sh");

        // LB at 0x102: ready in cycle 0, rvalid in cycle 2.
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 5'd7, 32'h1014);
        mem_ready = 1'b1;
        #1;
        chk("lb_c0_mem_req", {31'd0, mem_req}, 32'd1);
        chk("lb_c0_mem_we", {31'd0, mem_we}, 32'd0);
        chk("lb_c0_mem_be", {28'd0, mem_be}, 32'd0);
        chk("lb_c0_StallM", {31'd0, StallM}, 32'd1);
        push(1'b1, 32'hFFFFFF80);
        tick();
        check_bubble("lb_c0");
        mem_ready = 1'b0;
        #1;
        chk("lb_c1_mem_req", {31'd0, mem_req}, 32'd0);
        chk("lb_c1_StallM", {31'd0, StallM}, 32'd1);
        tick();
        check_bubble("lb_c1");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12804567;
        #1;
        chk("lb_c2_StallM", {31'd0, StallM}, 32'd0);
        tick();
        check_wb("lb");
        mem_rvalid = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
        tick();
        check_bubble("lb_single_pulse");

        // LHU at 0x102, minimum latency.
        drive(1'b1, 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd8, 32'h1018);
        mem_ready = 1'b1;
        push(1'b1, 32'h00001280);
        tick();
        check_bubble("lhu_c0");
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        chk("lhu_c1_StallM", {31'd0, StallM}, 32'd0);
        tick();
        check_wb("lhu");
        mem_rvalid = 1'b0;

        // LW passes the whole word.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 5'd10, 32'h101C);
        mem_ready = 1'b1;
        push(1'b1, 32'h12804567);
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        tick();
        check_wb("lw");
        mem_rvalid = 1'b0;

        // SW held off for 3 cycles.
        drive(1'b0, 1'b0, 1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 5'd0, 32'h1020);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sw_wait_mem_req", {31'd0, mem_req}, 32'd1);
            chk("sw_wait_mem_addr", mem_addr, 32'h200);
            chk("sw_wait_mem_wdata", mem_wdata, 32'hDEADBEEF);
            chk("sw_wait_mem_be", {28'd0, mem_be}, 32'hF);
            chk("sw_wait_StallM", {31'd0, StallM}, 32'd1);
            tick();
            check_bubble("sw_wait");
        end
        mem_ready = 1'b1;
        #1;
        chk("sw_done_StallM", {31'd0, StallM}, 32'd0);
        push(1'b0, 32'h0);
        tick();
        check_wb("sw");

        // Misaligned LW.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd11, 32'h1024);
        #1;
        chk("mis_mem_req", {31'd0, mem_req}, 32'd0);
        chk("mis_StallM", {31'd0, StallM}, 32'd0);
        tick();
        chk("mis_MisalignW", {31'd0, MisalignW}, 32'd1);
        check_bubble("mis");
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
        tick();
        chk("mis_pulse_end", {31'd0, MisalignW}, 32'd0);

        // Reset while waiting for a response; late rvalid must be ignored.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd12, 32'h1028);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        rst       = 1'b1;
        tick();
        chk("rstw_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        chk("rstw_RdW", {27'd0, RdW}, 32'd0);
        chk("rstw_ReadDataW", ReadDataW, 32'd0);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h99, 32'h0, 5'd9, 32'h102C);
        #1;
        chk("rstw_alu_StallM", {31'd0, StallM}, 32'd0);
        chk("rstw_alu_mem_req", {31'd0, mem_req}, 32'd0);
        push(1'b0, 32'h0);
        tick();
        check_wb("rstw_alu");
        mem_rvalid = 1'b0;

        chk("sb_drained", wb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
